// File: rtl/mmio_bus.sv
// -----------------------------------------------------------------------------
// mmio_bus
// Memory-mapped I/O fabric between the CPU data port and the RAM.
//
// The address MSB selects the region: 0 = RAM, 1 = I/O.
// All I/O offsets below are relative to the start of the I/O region (0x100).
//   0x00+k : output register k, read/write
//   0x40+k : synchronised input k, read-only, zero-extended
//   0x60+k : change flag k in bit 0, read-clear
//   0x80   : free-running cycle counter, read; a write loads it
// Every other I/O offset is unmapped.
//
// All read data has a uniform latency of one cycle.
//
// Ports
//   clk         clock; all state updates on the rising edge
//   reset       asynchronous active-low reset
//   mem_addr    CPU address
//   mem_cmd     CPU command: 00 none, 01 read, 10 write, 11 illegal
//   write_data  CPU write data
//   read_data   read data, valid the cycle after the read command
//   ram_addr    RAM address (low RAM_AW bits of mem_addr)
//   ram_din     RAM write data (equal to write_data)
//   ram_we      RAM write enable (combinational)
//   ram_dout    synchronous RAM read data, one-cycle latency
//   in_ports    asynchronous input channels, channel k at [k*IN_W +: IN_W]
//   out_ports   output register contents, same packing as in_ports
//   bad_access  sticky error flag; cleared only by reset
// -----------------------------------------------------------------------------
module mmio_bus #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 16,
  parameter int RAM_AW  = 8,
  parameter int NUM_OUT = 2,
  parameter int NUM_IN  = 2,
  parameter int OUT_W   = 8,
  parameter int IN_W    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         mem_addr,
  input  logic [1:0]                mem_cmd,
  input  logic [DATA_W-1:0]         write_data,
  output logic [DATA_W-1:0]         read_data,
  output logic [RAM_AW-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_din,
  output logic                      ram_we,
  input  logic [DATA_W-1:0]         ram_dout,
  input  logic [NUM_IN*IN_W-1:0]    in_ports,
  output logic [NUM_OUT*OUT_W-1:0]  out_ports,
  output logic                      bad_access
);

  localparam int OFF_W    = ADDR_W - 1;
  localparam int OFF_IN   = 64;   // 0x40
  localparam int OFF_FLAG = 96;   // 0x60
  localparam int OFF_CNT  = 128;  // 0x80

  // ---------------------------------------------------------------------------
  // Command and region decode
  // ---------------------------------------------------------------------------
  logic             rd_s;
  logic             wr_s;
  logic             ill_s;
  logic             io_sel_s;
  logic [OFF_W-1:0] io_off_s;

  assign rd_s     = (mem_cmd == 2'b01);
  assign wr_s     = (mem_cmd == 2'b10);
  assign ill_s    = (mem_cmd == 2'b11);
  assign io_sel_s = mem_addr[ADDR_W-1];
  assign io_off_s = mem_addr[ADDR_W-2:0];

  assign ram_addr = mem_addr[RAM_AW-1:0];
  assign ram_din  = write_data;
  // The illegal command decodes as neither read nor write, so it can never
  // reach the RAM or any register.
  assign ram_we   = wr_s & ~io_sel_s;

  logic [NUM_OUT-1:0] out_hit_s;
  logic [NUM_IN-1:0]  in_hit_s;
  logic [NUM_IN-1:0]  flag_hit_s;
  logic               cnt_hit_s;
  logic               wr_mapped_s;

  // Per-channel I/O address match
  always_comb begin
    out_hit_s  = {NUM_OUT{1'b0}};
    in_hit_s   = {NUM_IN{1'b0}};
    flag_hit_s = {NUM_IN{1'b0}};
    for (int k = 0; k < NUM_OUT; k++) begin
      out_hit_s[k] = io_sel_s && (io_off_s == OFF_W'(k));
    end
    for (int k = 0; k < NUM_IN; k++) begin
      in_hit_s[k]   = io_sel_s && (io_off_s == OFF_W'(OFF_IN + k));
      flag_hit_s[k] = io_sel_s && (io_off_s == OFF_W'(OFF_FLAG + k));
    end
  end

  assign cnt_hit_s   = io_sel_s && (io_off_s == OFF_W'(OFF_CNT));
  // Only output registers and the counter accept writes.
  assign wr_mapped_s = (|out_hit_s) | cnt_hit_s;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_OUT-1:0][OUT_W-1:0] out_q,   out_d;
  logic [NUM_IN-1:0][IN_W-1:0]   sync1_q, sync1_d;
  logic [NUM_IN-1:0][IN_W-1:0]   sync2_q, sync2_d;
  logic [NUM_IN-1:0][IN_W-1:0]   prev_q,  prev_d;
  logic [NUM_IN-1:0]             flag_q,  flag_d;
  logic [NUM_IN-1:0]             change_s;
  logic [DATA_W-1:0]             cnt_q,   cnt_d;
  logic [DATA_W-1:0]             io_rd_q, io_rd_d;
  logic                          rd_src_q, rd_src_d;
  logic                          bad_q,   bad_d;
  logic [DATA_W-1:0]             io_rdata_s;

  // Output register write
  always_comb begin
    out_d = out_q;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (wr_s && out_hit_s[k]) begin
        out_d[k] = write_data[OUT_W-1:0];
      end else begin
        out_d[k] = out_q[k];
      end
    end
  end

  // Input synchroniser chain and change detection
  always_comb begin
    sync1_d  = in_ports;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    change_s = {NUM_IN{1'b0}};
    for (int k = 0; k < NUM_IN; k++) begin
      change_s[k] = (sync2_q[k] != prev_q[k]);
    end
    // A read clears the flag, but a change in the same cycle wins.
    flag_d = (flag_q & ~(flag_hit_s & {NUM_IN{rd_s}})) | change_s;
  end

  // Cycle counter: a write replaces that cycle's increment
  always_comb begin
    if (wr_s && cnt_hit_s) begin
      cnt_d = write_data;
    end else begin
      cnt_d = cnt_q + DATA_W'(1);
    end
  end

  // I/O read mux; sources are one-hot so they are OR-combined, unmapped gives 0
  always_comb begin
    io_rdata_s = {DATA_W{1'b0}};
    for (int k = 0; k < NUM_OUT; k++) begin
      io_rdata_s = io_rdata_s | (out_hit_s[k] ? DATA_W'(out_q[k]) : {DATA_W{1'b0}});
    end
    for (int k = 0; k < NUM_IN; k++) begin
      io_rdata_s = io_rdata_s | (in_hit_s[k] ? DATA_W'(sync2_q[k]) : {DATA_W{1'b0}});
      io_rdata_s = io_rdata_s | (flag_hit_s[k] ? DATA_W'(flag_q[k]) : {DATA_W{1'b0}});
    end
    // The counter value seen is the one before this edge's increment.
    io_rdata_s = io_rdata_s | (cnt_hit_s ? cnt_q : {DATA_W{1'b0}});
  end

  // Read capture, source select and sticky error
  always_comb begin
    if (rd_s) begin
      rd_src_d = io_sel_s;
    end else begin
      rd_src_d = rd_src_q;
    end
    if (rd_s && io_sel_s) begin
      io_rd_d = io_rdata_s;
    end else begin
      io_rd_d = io_rd_q;
    end
    bad_d = bad_q | ill_s | (wr_s & io_sel_s & ~wr_mapped_s);
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q    <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      flag_q   <= {NUM_IN{1'b0}};
      cnt_q    <= {DATA_W{1'b0}};
      io_rd_q  <= {DATA_W{1'b0}};
      rd_src_q <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      flag_q   <= flag_d;
      cnt_q    <= cnt_d;
      io_rd_q  <= io_rd_d;
      rd_src_q <= rd_src_d;
      bad_q    <= bad_d;
    end
  end

  // RAM data is already registered inside the RAM, so only the select is ours.
  assign read_data  = rd_src_q ? io_rd_q : ram_dout;
  assign out_ports  = out_q;
  assign bad_access = bad_q;

endmodule

// File: tb/tb_mmio_bus.sv
module tb_mmio_bus;

  logic        clk;
  logic        reset;
  logic [8:0]  mem_addr;
  logic [1:0]  mem_cmd;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din;
  logic        ram_we;
  logic [15:0] ram_dout;
  logic [15:0] in_ports;
  logic [15:0] out_ports;
  logic        bad_access;

  int checks;
  int errors;

  logic [15:0] mem [256];

  mmio_bus dut (
    .clk        (clk),
    .reset      (reset),
    .mem_addr   (mem_addr),
    .mem_cmd    (mem_cmd),
    .write_data (write_data),
    .read_data  (read_data),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout),
    .in_ports   (in_ports),
    .out_ports  (out_ports),
    .bad_access (bad_access)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous read-first RAM model
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic        chk_rd;
    logic [15:0] exp_rd;
    logic [15:0] exp_out;
    logic        exp_bad;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd);
    mem_cmd    = cmd;
    mem_addr   = addr;
    write_data = wd;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    ram_dout = 16'h0000;

    //                 cmd    addr     wdata     chk   exp_rd    exp_out   bad
    vecs[0]  = '{2'b10, 9'h100, 16'h00A5, 1'b0, 16'h0000, 16'h00A5, 1'b0};
    vecs[1]  = '{2'b10, 9'h101, 16'h003C, 1'b0, 16'h0000, 16'h3CA5, 1'b0};
    vecs[2]  = '{2'b01, 9'h101, 16'h0000, 1'b1, 16'h003C, 16'h3CA5, 1'b0};
    vecs[3]  = '{2'b00, 9'h000, 16'h0000, 1'b1, 16'h003C, 16'h3CA5, 1'b0};
    vecs[4]  = '{2'b01, 9'h100, 16'h0000, 1'b1, 16'h00A5, 16'h3CA5, 1'b0};
    vecs[5]  = '{2'b01, 9'h1F0, 16'h0000, 1'b1, 16'h0000, 16'h3CA5, 1'b0};
    vecs[6]  = '{2'b10, 9'h180, 16'hFFFE, 1'b0, 16'h0000, 16'h3CA5, 1'b0};
    vecs[7]  = '{2'b00, 9'h000, 16'h0000, 1'b0, 16'h0000, 16'h3CA5, 1'b0};
    vecs[8]  = '{2'b01, 9'h180, 16'h0000, 1'b1, 16'hFFFF, 16'h3CA5, 1'b0};
    vecs[9]  = '{2'b01, 9'h180, 16'h0000, 1'b1, 16'h0000, 16'h3CA5, 1'b0};
    vecs[10] = '{2'b01, 9'h180, 16'h0000, 1'b1, 16'h0001, 16'h3CA5, 1'b0};
    vecs[11] = '{2'b10, 9'h100, 16'hBE77, 1'b0, 16'h0000, 16'h3C77, 1'b0};
    vecs[12] = '{2'b01, 9'h100, 16'h0000, 1'b1, 16'h0077, 16'h3C77, 1'b0};
    vecs[13] = '{2'b01, 9'h140, 16'h0000, 1'b1, 16'h0000, 16'h3C77, 1'b0};

    reset    = 1'b0;
    in_ports = 16'h0000;
    drive(2'b00, 9'h000, 16'h0000);
    tick;
    tick;
    reset = 1'b1;

    // Reset state
    chk("rst_read_data", read_data, 16'h0000);
    chk("rst_out_ports", out_ports, 16'h0000);
    chk("rst_bad", bad_access, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);

    // Table-driven register / counter accesses
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].cmd, vecs[i].addr, vecs[i].wdata);
      tick;
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_read_data", i), read_data, vecs[i].exp_rd);
      chk($sformatf("vec%0d_out_ports", i), out_ports, vecs[i].exp_out);
      chk($sformatf("vec%0d_bad", i), bad_access, vecs[i].exp_bad);
    end
    drive(2'b00, 9'h000, 16'h0000);

    // Input synchroniser and change flag
    in_ports = 16'h005A;
    repeat (4) tick;
    drive(2'b01, 9'h140, 16'h0000); tick;
    chk("in0_value", read_data, 16'h005A);
    drive(2'b01, 9'h160, 16'h0000); tick;
    chk("flag0_first_read", read_data, 16'h0001);
    drive(2'b01, 9'h160, 16'h0000); tick;
    chk("flag0_cleared", read_data, 16'h0000);
    drive(2'b01, 9'h161, 16'h0000); tick;
    chk("flag1_idle", read_data, 16'h0000);

    // Set wins over read-clear: change detection lands on the read edge
    drive(2'b00, 9'h000, 16'h0000);
    in_ports = 16'h115A;
    repeat (4) tick;
    in_ports = 16'h225A;
    tick;
    tick;
    drive(2'b01, 9'h161, 16'h0000); tick;
    chk("flag1_read_old", read_data, 16'h0001);
    drive(2'b01, 9'h161, 16'h0000); tick;
    chk("flag1_set_wins", read_data, 16'h0001);
    drive(2'b01, 9'h161, 16'h0000); tick;
    chk("flag1_cleared", read_data, 16'h0000);
    drive(2'b01, 9'h141, 16'h0000); tick;
    chk("in1_value", read_data, 16'h0022);

    // RAM write then read
    drive(2'b10, 9'h012, 16'h1234);
    #1;
    chk("ram_we_write", ram_we, 1'b1);
    chk("ram_addr", ram_addr, 8'h12);
    chk("ram_din", ram_din, 16'h1234);
    tick;
    drive(2'b01, 9'h012, 16'h0000);
    #1;
    chk("ram_we_read", ram_we, 1'b0);
    tick;
    chk("ram_read_data", read_data, 16'h1234);
    chk("ram_out_untouched", out_ports, 16'h3C77);
    chk("bad_still_clear", bad_access, 1'b0);

    // Write to read-only input address
    drive(2'b10, 9'h140, 16'hFFFF); tick;
    chk("ro_write_bad", bad_access, 1'b1);
    chk("ro_write_out", out_ports, 16'h3C77);
    drive(2'b00, 9'h000, 16'h0000); tick;
    chk("bad_sticky", bad_access, 1'b1);

    // Asynchronous reset mid-write: nothing of the write survives
    drive(2'b10, 9'h100, 16'h0055);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_out", out_ports, 16'h0000);
    chk("async_rst_bad", bad_access, 1'b0);
    tick;
    drive(2'b00, 9'h000, 16'h0000);
    reset = 1'b1;
    tick;
    chk("no_partial_write", out_ports, 16'h0000);

    // Unmapped write
    drive(2'b10, 9'h1F0, 16'h00AA); tick;
    chk("unmapped_bad", bad_access, 1'b1);
    chk("unmapped_out", out_ports, 16'h0000);
    drive(2'b00, 9'h000, 16'h0000);
    reset = 1'b0; tick; reset = 1'b1;
    chk("bad_cleared_by_reset", bad_access, 1'b0);

    // Illegal command: no register or RAM write
    drive(2'b11, 9'h100, 16'h00FF);
    #1;
    chk("ill_io_ram_we", ram_we, 1'b0);
    tick;
    chk("ill_bad", bad_access, 1'b1);
    chk("ill_out", out_ports, 16'h0000);
    drive(2'b11, 9'h012, 16'hDEAD);
    #1;
    chk("ill_ram_we", ram_we, 1'b0);
    tick;
    drive(2'b01, 9'h012, 16'h0000); tick;
    chk("ill_ram_kept", read_data, 16'h1234);
    chk("ill_bad_sticky", bad_access, 1'b1);
    drive(2'b00, 9'h000, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
